gpio_in_conditioner: RTL and testbench
======================================

GPIO_IN_CONDITIONER -- requirements
Module: gpio_in_conditioner

Interface
REQ-001 Parameter WIDTH, default 8: number of GPIO input bits.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive cycles a synchronized input must differ from the stable value before the stable value updates; legal range >= 1.
REQ-003 Parameter RESET_VAL, default 0 (WIDTH bits): reset value of the synchronizer and stable registers.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-low (0 = reset).
REQ-006 Port pad_in, input, WIDTH: raw asynchronous switch/pin inputs.
REQ-007 Port edge_clr, input, WIDTH: per-bit clear of rise_pending and fall_pending.
REQ-008 Port irq_mask, input, WIDTH: per-bit enable for irq.
REQ-009 Port gpio_port_in, output, WIDTH: debounced stable level; drives the CPU GPIO input port.
REQ-010 Port rise_pending, output, WIDTH: sticky flags for 0->1 transitions of gpio_port_in.
REQ-011 Port fall_pending, output, WIDTH: sticky flags for 1->0 transitions of gpio_port_in.
REQ-012 Port irq, output, 1: combinational OR over (rise_pending | fall_pending) & irq_mask.

Function
REQ-013 Each bit SHALL pass through a two-flop synchronizer (sync1 <- pad_in, sync2 <- sync1) before any other use.
REQ-014 Each bit SHALL own a counter of width max(1, $clog2(DEBOUNCE_CYCLES)) bits.
REQ-015 Per edge, sync2[i] == stable[i]: the counter clears to 0 and stable holds.
REQ-016 Per edge, sync2[i] != stable[i] and counter == DEBOUNCE_CYCLES-1: stable[i] <= sync2[i] and the counter clears; otherwise the counter increments.
REQ-017 A pad_in change first sampled at edge N and held SHALL update gpio_port_in at edge N+1+DEBOUNCE_CYCLES, and not before.
REQ-018 A pad_in pulse or bounce lasting fewer than DEBOUNCE_CYCLES synchronized cycles SHALL leave gpio_port_in unchanged, with the counter back at 0.
REQ-019 DEBOUNCE_CYCLES == 1 SHALL update stable on the first differing edge.
REQ-020 On the edge where stable[i] goes 0->1, rise_pending[i] SHALL set; on 1->0, fall_pending[i] SHALL set. Flags are registered and visible the same cycle as the new gpio_port_in.
REQ-021 edge_clr[i] == 1 at an edge SHALL clear both pending flags of bit i on that edge.
REQ-022 Simultaneous set and clear on the same bit and edge: set wins, so the flag reads 1.
REQ-023 Bits SHALL be fully independent; no cross-bit interaction except irq.
REQ-024 gpio_port_in, rise_pending and fall_pending SHALL be driven directly from flops.

Reset
REQ-025 While rst == 0 at an edge: sync1, sync2 and stable <= RESET_VAL; counters <= 0; rise_pending and fall_pending <= 0; hence irq = 0.
REQ-026 Reset asserted mid-debounce SHALL discard the partial count; no pending flag is set by reset itself.
REQ-027 After rst deasserts, a pad_in differing from RESET_VAL SHALL be handled as a normal change per REQ-017, producing a pending flag.

Configuration
REQ-028 Macro GPIO_EDGE_CAPTURE_EN defined: edge flags, edge_clr and irq operate per REQ-020..REQ-022 and REQ-012.
REQ-029 Macro GPIO_EDGE_CAPTURE_EN undefined: no pending flops exist; rise_pending, fall_pending and irq are tied to 0; edge_clr and irq_mask are ignored. Ports remain present.

Verification (WIDTH=8, DEBOUNCE_CYCLES=4, RESET_VAL=0, GPIO_EDGE_CAPTURE_EN defined unless stated)
REQ-030 Reset, then pad_in 0x00->0x02 held from edge 0 -> gpio_port_in = 0x02 after edge 5 and not after edge 4; rise_pending = 0x02; irq = 1 with irq_mask = 0xFF.
REQ-031 pad_in bit0 high for 3 cycles, then low -> gpio_port_in stays 0x00 and rise_pending stays 0x00.
REQ-032 With rise_pending = 0x02, edge_clr = 0x02 for 1 cycle -> rise_pending = 0x00 and irq = 0; edge_clr coinciding with the debounce-completion edge of a new 1->0 on bit1 -> fall_pending[1] = 1.
REQ-033 rst = 0 for 1 edge at debounce count 2 of a 0->0x80 change, pad_in still held -> counters = 0, gpio_port_in = 0x00, pending = 0x00; after release, gpio_port_in = 0x80 at 4 + 2 edges later.
REQ-034 Macro undefined, pad_in 0x00->0xFF -> gpio_port_in = 0xFF per REQ-017; rise_pending, fall_pending and irq constant 0.
REQ-035 Bits 0 and 7 toggled on the same edge, irq_mask = 0x01 -> both rise flags set; irq = 1; after edge_clr = 0x01, irq = 0 while rise_pending = 0x80.

Source files
------------

// File: rtl/gpio_in_conditioner.sv
// Two-flop synchronized, per-bit debounced GPIO inputs with sticky edge flags and a masked irq.
// Build option: define GPIO_EDGE_CAPTURE_EN to enable rise/fall pending flags and irq; otherwise they read 0.
module gpio_in_conditioner #(
  parameter int               WIDTH           = 8,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pad_in,
  input  logic [WIDTH-1:0] edge_clr,
  input  logic [WIDTH-1:0] irq_mask,
  output logic [WIDTH-1:0] gpio_port_in,
  output logic [WIDTH-1:0] rise_pending,
  output logic [WIDTH-1:0] fall_pending,
  output logic             irq
);

  localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] upd;

  // A bit commits when it has disagreed with the stable value for the full window.
  always_comb begin
    upd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      upd[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1  <= RESET_VAL;
      sync2  <= RESET_VAL;
      stable <= RESET_VAL;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= pad_in;
      sync2 <= sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i] || upd[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
        if (upd[i]) begin
          stable[i] <= sync2[i];
        end
      end
    end
  end

  assign gpio_port_in = stable;

`ifdef GPIO_EDGE_CAPTURE_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  // Set has priority over clear so an edge landing with edge_clr is never lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= (rise_q & ~edge_clr) | (upd & sync2);
      fall_q <= (fall_q & ~edge_clr) | (upd & ~sync2);
    end
  end

  assign rise_pending = rise_q;
  assign fall_pending = fall_q;
  assign irq          = |((rise_q | fall_q) & irq_mask);
`else
  logic unused_edge_inputs;
  assign unused_edge_inputs = ^{edge_clr, irq_mask};
  assign rise_pending       = '0;
  assign fall_pending       = '0;
  assign irq                = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner (WIDTH=8, DEBOUNCE_CYCLES=4, plus a DEBOUNCE_CYCLES=1 instance).
module tb_gpio_in_conditioner;

`ifdef GPIO_EDGE_CAPTURE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] pad_in   = '0;
  logic [7:0] edge_clr = '0;
  logic [7:0] irq_mask = 8'hFF;
  logic [7:0] gpio_port_in, rise_pending, fall_pending;
  logic       irq;
  logic [7:0] gpio1, rise1, fall1;
  logic       irq1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_in_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .pad_in(pad_in), .edge_clr(edge_clr), .irq_mask(irq_mask),
    .gpio_port_in(gpio_port_in), .rise_pending(rise_pending), .fall_pending(fall_pending), .irq(irq)
  );

  gpio_in_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(1), .RESET_VAL(8'h00)) dut1 (
    .clk(clk), .rst(rst), .pad_in(pad_in), .edge_clr(edge_clr), .irq_mask(irq_mask),
    .gpio_port_in(gpio1), .rise_pending(rise1), .fall_pending(fall1), .irq(irq1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    edge_clr = 8'hFF;
    tick();
    edge_clr = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pad_in = 8'h00;
    edge_clr = 8'h00;
    irq_mask = 8'hFF;
    tick();
    tick();
    checks++;
    if (gpio_port_in !== 8'h00 || rise_pending !== 8'h00 || fall_pending !== 8'h00 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: gpio=%h rise=%h fall=%h irq=%b, required 00 00 00 0",
               gpio_port_in, rise_pending, fall_pending, irq);
    end
    rst = 1'b1;
  endtask

  task automatic test_rise();
    pad_in = 8'h02;
    for (int e = 0; e <= 4; e++) begin
      tick();
      checks++;
      if (gpio_port_in !== 8'h00) begin
        errors++;
        $display("FAIL rise_early edge%0d: gpio=%h required 00", e, gpio_port_in);
      end
      if (e == 1) begin
        checks++;
        if (gpio1 !== 8'h00) begin
          errors++;
          $display("FAIL db1_early: gpio=%h required 00", gpio1);
        end
      end
      if (e == 2) begin
        checks++;
        if (gpio1 !== 8'h02) begin
          errors++;
          $display("FAIL db1_update: gpio=%h required 02", gpio1);
        end
      end
    end
    tick();
    checks++;
    if (gpio_port_in !== 8'h02) begin
      errors++;
      $display("FAIL rise_update: gpio=%h required 02", gpio_port_in);
    end
    checks++;
    if (rise_pending !== (EDGE_EN ? 8'h02 : 8'h00) || fall_pending !== 8'h00 || irq !== EDGE_EN) begin
      errors++;
      $display("FAIL rise_flags: rise=%h fall=%h irq=%b, required %h 00 %b",
               rise_pending, fall_pending, irq, EDGE_EN ? 8'h02 : 8'h00, EDGE_EN);
    end
  endtask

  task automatic test_clear();
    edge_clr = 8'h02;
    tick();
    edge_clr = 8'h00;
    checks++;
    if (rise_pending !== 8'h00 || irq !== 1'b0) begin
      errors++;
      $display("FAIL clear_rise: rise=%h irq=%b, required 00 0", rise_pending, irq);
    end
    pad_in = 8'h00;
    repeat (5) tick();
    edge_clr = 8'h02;
    tick();
    edge_clr = 8'h00;
    checks++;
    if (gpio_port_in !== 8'h00 || fall_pending !== (EDGE_EN ? 8'h02 : 8'h00)) begin
      errors++;
      $display("FAIL set_beats_clear: gpio=%h fall=%h, required 00 %h",
               gpio_port_in, fall_pending, EDGE_EN ? 8'h02 : 8'h00);
    end
    clear_all();
    checks++;
    if (fall_pending !== 8'h00 || rise_pending !== 8'h00) begin
      errors++;
      $display("FAIL clear_fall: rise=%h fall=%h, required 00 00", rise_pending, fall_pending);
    end
  endtask

  task automatic test_glitch();
    pad_in = 8'h01;
    repeat (3) tick();
    pad_in = 8'h00;
    repeat (8) tick();
    checks++;
    if (gpio_port_in !== 8'h00 || rise_pending !== 8'h00) begin
      errors++;
      $display("FAIL glitch: gpio=%h rise=%h, required 00 00", gpio_port_in, rise_pending);
    end
    // A full-length change afterwards must still take the whole window (counter back at 0).
    pad_in = 8'h01;
    repeat (5) tick();
    checks++;
    if (gpio_port_in !== 8'h00) begin
      errors++;
      $display("FAIL glitch_cnt_cleared: gpio=%h required 00", gpio_port_in);
    end
    tick();
    checks++;
    if (gpio_port_in !== 8'h01) begin
      errors++;
      $display("FAIL after_glitch_update: gpio=%h required 01", gpio_port_in);
    end
    pad_in = 8'h00;
    repeat (6) tick();
    checks++;
    if (gpio_port_in !== 8'h00 || fall_pending !== (EDGE_EN ? 8'h01 : 8'h00)) begin
      errors++;
      $display("FAIL bit0_fall: gpio=%h fall=%h, required 00 %h",
               gpio_port_in, fall_pending, EDGE_EN ? 8'h01 : 8'h00);
    end
    clear_all();
  endtask

  task automatic test_reset_mid();
    pad_in = 8'h80;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (gpio_port_in !== 8'h00 || rise_pending !== 8'h00 || fall_pending !== 8'h00 || irq !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: gpio=%h rise=%h fall=%h irq=%b, required 00 00 00 0",
               gpio_port_in, rise_pending, fall_pending, irq);
    end
    repeat (5) tick();
    checks++;
    if (gpio_port_in !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_early: gpio=%h required 00", gpio_port_in);
    end
    tick();
    checks++;
    if (gpio_port_in !== 8'h80 || rise_pending !== (EDGE_EN ? 8'h80 : 8'h00)) begin
      errors++;
      $display("FAIL mid_reset_resume: gpio=%h rise=%h, required 80 %h",
               gpio_port_in, rise_pending, EDGE_EN ? 8'h80 : 8'h00);
    end
    pad_in = 8'h00;
    repeat (6) tick();
    clear_all();
  endtask

  task automatic test_back_to_back();
    irq_mask = 8'h01;
    pad_in = 8'h81;
    repeat (6) tick();
    checks++;
    if (gpio_port_in !== 8'h81 || rise_pending !== (EDGE_EN ? 8'h81 : 8'h00) || irq !== EDGE_EN) begin
      errors++;
      $display("FAIL two_bits: gpio=%h rise=%h irq=%b, required 81 %h %b",
               gpio_port_in, rise_pending, irq, EDGE_EN ? 8'h81 : 8'h00, EDGE_EN);
    end
    edge_clr = 8'h01;
    tick();
    edge_clr = 8'h00;
    checks++;
    if (irq !== 1'b0 || rise_pending !== (EDGE_EN ? 8'h80 : 8'h00)) begin
      errors++;
      $display("FAIL masked_irq: irq=%b rise=%h, required 0 %h",
               irq, rise_pending, EDGE_EN ? 8'h80 : 8'h00);
    end
    irq_mask = 8'hFF;
    pad_in = 8'h00;
    repeat (6) tick();
    clear_all();
  endtask

  task automatic test_all_bits();
    pad_in = 8'hFF;
    for (int e = 0; e <= 4; e++) begin
      tick();
      checks++;
      if (gpio_port_in !== 8'h00) begin
        errors++;
        $display("FAIL all_early edge%0d: gpio=%h required 00", e, gpio_port_in);
      end
    end
    tick();
    checks++;
    if (gpio_port_in !== 8'hFF || rise_pending !== (EDGE_EN ? 8'hFF : 8'h00) ||
        fall_pending !== 8'h00 || irq !== EDGE_EN) begin
      errors++;
      $display("FAIL all_update: gpio=%h rise=%h fall=%h irq=%b, required ff %h 00 %b",
               gpio_port_in, rise_pending, fall_pending, irq, EDGE_EN ? 8'hFF : 8'h00, EDGE_EN);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_clear();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    test_all_bits();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
